// File: rtl/ce_bank_if.sv
// Configuration write port of the clock-enable bank.
// The master side selects a channel and supplies its INC/MOD pair for one cycle.
interface ce_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] mod;

  modport master (output wr, addr, inc, mod);
  modport slave  (input  wr, addr, inc, mod);
endinterface

// File: rtl/ce_bank.sv
// Bank of fractional clock-enable generators sharing one master clock.
// Each channel emits a one-cycle ce strobe at clock*INC/MOD on average and a
// square wave sq that flips on every strobe. Everything is held off until the
// synchronised PLL lock has been continuously high for LOCK_CYCLES cycles.
module ce_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int RESET_INC   = 1,
  parameter int RESET_MOD   = 3
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                locked_i,
  input  logic                sync_i,
  ce_bank_if.slave            cfg,
  output logic [CHANNELS-1:0] ce_o,
  output logic [CHANNELS-1:0] sq_o,
  output logic                ready_o
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);

  logic                lockMeta_q;
  logic                lockSync_q;
  logic [CW-1:0]       lockCnt_q;
  logic [CW-1:0]       lockCnt_d;
  logic                ready_q;
  logic                ready_d;
  logic                run;

  logic [WIDTH-1:0]    inc_q  [CHANNELS];
  logic [WIDTH-1:0]    inc_d  [CHANNELS];
  logic [WIDTH-1:0]    mod_q  [CHANNELS];
  logic [WIDTH-1:0]    mod_d  [CHANNELS];
  logic [WIDTH-1:0]    acc_q  [CHANNELS];
  logic [WIDTH-1:0]    acc_d  [CHANNELS];
  logic [WIDTH:0]      sum    [CHANNELS];
  logic [WIDTH:0]      diff   [CHANNELS];
  logic [CHANNELS-1:0] ce_q;
  logic [CHANNELS-1:0] ce_d;
  logic [CHANNELS-1:0] sq_q;
  logic [CHANNELS-1:0] sq_d;
  logic [CHANNELS-1:0] wrHit;

  // Channels only run while lock is qualified and the synchronised lock is
  // still high, so a lock drop silences them on the same edge ready falls.
  assign run = ready_q & lockSync_q;

  // Lock qualification: count consecutive lock cycles, saturate at the target.
  always_comb begin
    lockCnt_d = lockCnt_q;
    ready_d   = ready_q;
    if (!lockSync_q) begin
      lockCnt_d = '0;
      ready_d   = 1'b0;
    end else if (lockCnt_q != CW'(LOCK_CYCLES)) begin
      lockCnt_d = lockCnt_q + CW'(1);
      ready_d   = (lockCnt_q + CW'(1)) == CW'(LOCK_CYCLES);
    end else begin
      ready_d   = 1'b1;
    end
  end

  // Per-channel next state: register writes, restart clears, then accumulation.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      wrHit[n] = cfg.wr && (int'(cfg.addr) == n);
      inc_d[n] = inc_q[n];
      mod_d[n] = mod_q[n];
      acc_d[n] = acc_q[n];
      ce_d[n]  = 1'b0;
      sq_d[n]  = sq_q[n];
      sum[n]   = {1'b0, acc_q[n]} + {1'b0, inc_q[n]};
      diff[n]  = sum[n] - {1'b0, mod_q[n]};
      if (wrHit[n]) begin
        inc_d[n] = cfg.inc;
        mod_d[n] = cfg.mod;
      end
      if (!run) begin
        acc_d[n] = '0;
        sq_d[n]  = 1'b0;
      end else if (sync_i || wrHit[n]) begin
        acc_d[n] = '0;
        sq_d[n]  = 1'b0;
      end else if ((mod_q[n] == '0) || (inc_q[n] == '0)) begin
        acc_d[n] = '0;
      end else if (inc_q[n] >= mod_q[n]) begin
        acc_d[n] = '0;
        ce_d[n]  = 1'b1;
        sq_d[n]  = ~sq_q[n];
      end else if (sum[n] >= {1'b0, mod_q[n]}) begin
        acc_d[n] = diff[n][WIDTH-1:0];
        ce_d[n]  = 1'b1;
        sq_d[n]  = ~sq_q[n];
      end else begin
        acc_d[n] = sum[n][WIDTH-1:0];
      end
    end
  end

  // State registers; reset restores the default rate in every channel.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lockMeta_q <= 1'b0;
      lockSync_q <= 1'b0;
      lockCnt_q  <= '0;
      ready_q    <= 1'b0;
      ce_q       <= '0;
      sq_q       <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        inc_q[n] <= WIDTH'(RESET_INC);
        mod_q[n] <= WIDTH'(RESET_MOD);
        acc_q[n] <= '0;
      end
    end else begin
      lockMeta_q <= locked_i;
      lockSync_q <= lockMeta_q;
      lockCnt_q  <= lockCnt_d;
      ready_q    <= ready_d;
      ce_q       <= ce_d;
      sq_q       <= sq_d;
      for (int n = 0; n < CHANNELS; n++) begin
        inc_q[n] <= inc_d[n];
        mod_q[n] <= mod_d[n];
        acc_q[n] <= acc_d[n];
      end
    end
  end

  assign ce_o    = ce_q;
  assign sq_o    = sq_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_ce_bank.sv
// Directed bench for ce_bank: lock qualification, per-channel rate vectors,
// sync restart, lock loss/re-lock and asynchronous reset during operation.
module tb_ce_bank;
  localparam int CH  = 5;
  localparam int W   = 16;
  localparam int LC  = 8;

  logic          clock;
  logic          reset_n;
  logic          locked;
  logic          sync;
  logic [CH-1:0] ce;
  logic [CH-1:0] sq;
  logic          ready;

  int nChecks = 0;
  int nFail   = 0;

  ce_bank_if #(.CHANNELS(CH), .WIDTH(W)) cfg ();

  ce_bank #(
    .CHANNELS(CH), .WIDTH(W), .LOCK_CYCLES(LC), .RESET_INC(1), .RESET_MOD(3)
  ) dut (
    .clock_i(clock), .reset_ni(reset_n), .locked_i(locked), .sync_i(sync),
    .cfg(cfg), .ce_o(ce), .sq_o(sq), .ready_o(ready)
  );

  typedef struct {
    int addr;
    int incV;
    int modV;
    int cycles;
    int expCount;
    int expFirst;
    int expMinGap;
    int expMaxGap;
  } vec_t;

  vec_t vecs[9];

  // Free-running master clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of write/sync inputs, then clear them after the edge.
  task automatic applyStimulus(input logic wrV, input int addrV, input int incV, input int modV, input logic syncV);
    cfg.wr   = wrV;
    cfg.addr = 3'(addrV);
    cfg.inc  = W'(incV);
    cfg.mod  = W'(modV);
    sync     = syncV;
    tick();
    cfg.wr   = 1'b0;
    sync     = 1'b0;
  endtask

  // Wait through lock qualification and check ready at edges 9 and 10.
  task automatic qualifyLock(input string tag);
    for (int e = 1; e <= LC + 2; e++) begin
      tick();
      if (e == LC + 1) checkOutput({tag, "_ready_early"}, 32'(ready), 32'd0);
      if (e == LC + 2) checkOutput({tag, "_ready_rise"}, 32'(ready), 32'd1);
    end
  endtask

  // Expected ce pattern for the configuration ch0=1/3, ch1=1/2, ch2=10/4, ch3=5/5, ch4=1/2.
  function automatic logic [CH-1:0] mixedPattern(input int k);
    logic [CH-1:0] p;
    p[0] = (k % 3) == 0;
    p[1] = (k % 2) == 0;
    p[2] = 1'b1;
    p[3] = 1'b1;
    p[4] = (k % 2) == 0;
    return p;
  endfunction

  initial begin
    int cnt, first, last, minG, maxG, toggles, gap, a;
    logic prevSq;
    logic [CH-1:0] expSq;

    vecs[0] = '{1,   7, 100, 1000, 70, 15, 14, 15};
    vecs[1] = '{2,   0,   3,   30,  0,  0,  0,  0};
    vecs[2] = '{3,   5,   5,   20, 20,  1,  1,  1};
    vecs[3] = '{4,   1,   2,   20, 10,  2,  2,  2};
    vecs[4] = '{0,   3,   8,   80, 30,  3,  2,  3};
    vecs[5] = '{2,  10,   4,   10, 10,  1,  1,  1};
    vecs[6] = '{1,   3,   0,   20,  0,  0,  0,  0};
    vecs[7] = '{0,   1,   3,   30, 10,  3,  3,  3};
    vecs[8] = '{1,   1,   2,   20, 10,  2,  2,  2};

    reset_n  = 1'b0;
    locked   = 1'b0;
    sync     = 1'b0;
    cfg.wr   = 1'b0;
    cfg.addr = '0;
    cfg.inc  = '0;
    cfg.mod  = '0;
    repeat (2) tick();
    checkOutput("reset_ce", 32'(ce), 32'd0);
    checkOutput("reset_sq", 32'(sq), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);

    // Default rate 1/3 on every channel, phase-aligned after ready.
    reset_n = 1'b1;
    locked  = 1'b1;
    qualifyLock("lock");
    for (int k = 1; k <= 9; k++) begin
      tick();
      expSq = (((k / 3) % 2) == 1) ? '1 : '0;
      checkOutput($sformatf("default_ce_E%0d", k), 32'(ce), ((k % 3) == 0) ? 32'h1f : 32'h0);
      checkOutput($sformatf("default_sq_E%0d", k), 32'(sq), 32'(expSq));
    end

    // Table of per-channel rate vectors.
    for (int v = 0; v < 9; v++) begin
      a = vecs[v].addr;
      applyStimulus(1'b1, a, vecs[v].incV, vecs[v].modV, 1'b0);
      checkOutput($sformatf("vec%0d_sq_cleared", v), 32'(sq[a]), 32'd0);
      cnt = 0; first = 0; last = 0; minG = 0; maxG = 0; toggles = 0;
      prevSq = 1'b0;
      for (int i = 1; i <= vecs[v].cycles; i++) begin
        tick();
        if (ce[a]) begin
          if (cnt == 0) begin
            first = i;
          end else begin
            gap = i - last;
            if ((minG == 0) || (gap < minG)) minG = gap;
            if (gap > maxG) maxG = gap;
          end
          last = i;
          cnt++;
        end
        if (sq[a] != prevSq) toggles++;
        prevSq = sq[a];
      end
      checkOutput($sformatf("vec%0d_count", v), 32'(cnt), 32'(vecs[v].expCount));
      checkOutput($sformatf("vec%0d_first", v), 32'(first), 32'(vecs[v].expFirst));
      checkOutput($sformatf("vec%0d_mingap", v), 32'(minG), 32'(vecs[v].expMinGap));
      checkOutput($sformatf("vec%0d_maxgap", v), 32'(maxG), 32'(vecs[v].expMaxGap));
      checkOutput($sformatf("vec%0d_sqtoggles", v), 32'(toggles), 32'(vecs[v].expCount));
    end

    // Sync with channels at different phases, plus a write to a missing channel.
    repeat (5) tick();
    applyStimulus(1'b1, CH, 1, 7, 1'b1);
    checkOutput("sync_ce_cleared", 32'(ce), 32'd0);
    checkOutput("sync_sq_cleared", 32'(sq), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("sync_ce_E%0d", k), 32'(ce), 32'(mixedPattern(k)));
    end

    // Lock loss: ready and outputs drop on the third edge.
    repeat (4) tick();
    locked = 1'b0;
    tick();
    checkOutput("lockloss_ready_e1", 32'(ready), 32'd1);
    tick();
    checkOutput("lockloss_ready_e2", 32'(ready), 32'd1);
    tick();
    checkOutput("lockloss_ready_e3", 32'(ready), 32'd0);
    checkOutput("lockloss_ce_e3", 32'(ce), 32'd0);
    checkOutput("lockloss_sq_e3", 32'(sq), 32'd0);
    repeat (3) tick();
    locked = 1'b1;
    qualifyLock("relock");
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("relock_ce_E%0d", k), 32'(ce), 32'(mixedPattern(k)));
    end

    // Asynchronous reset between edges, then defaults restored.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_ce", 32'(ce), 32'd0);
    checkOutput("areset_sq", 32'(sq), 32'd0);
    checkOutput("areset_ready", 32'(ready), 32'd0);
    #1;
    reset_n = 1'b1;
    qualifyLock("postreset");
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("postreset_ce_E%0d", k), 32'(ce), (k == 3) ? 32'h1f : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
